cam_match_scan: RTL and testbench

Downstream consumer of the CAM lookup stage in the password-keeper datapath. The CAM returns a one-hot-per-slot match bitmap: bit i set means slot i holds the searched key. This block latches that bitmap on a start strobe and serialises it. It emits the index of every set bit, lowest index first, over a valid/ready stream, then reports completion, hit status and hit count.

---
 rtl/cam_match_scan.sv | 105 ++++++++++
 tb/tb_cam_match_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_match_scan.sv
// Serialises a latched CAM match bitmap into a stream of matched slot indices,
// lowest first, then reports completion, hit status and hit count.
module cam_match_scan #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [(1<<ADDR_WIDTH)-1:0]  match_vec,
  output logic                        busy,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [ADDR_WIDTH-1:0]       m_addr,
  output logic                        m_last,
  output logic                        done,
  output logic                        hit,
  output logic [ADDR_WIDTH:0]         hit_count
);

  localparam int N = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t              state, state_next;
  logic [N-1:0]        pending, pending_next;
  logic [N-1:0]        pending_low_cleared;
  logic [ADDR_WIDTH:0] count, count_next;
  logic                hit_next;
  logic                handshake;

  // x & (x-1) drops the lowest set bit; a zero result also means "one bit left".
  assign pending_low_cleared = pending & (pending - {{(N-1){1'b0}}, 1'b1});

  // Stream outputs come only from registered state, never from m_ready or start.
  always_comb begin
    m_valid = (state == SCAN) && (pending != '0);
    m_addr  = '0;
    if (m_valid) begin
      // Descending scan so the lowest set index is the one that sticks.
      for (int i = N - 1; i >= 0; i--) begin
        if (pending[i]) m_addr = ADDR_WIDTH'(i);
      end
    end
    m_last = m_valid && (pending_low_cleared == '0);
  end

  assign handshake = m_valid && m_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign hit_count = count;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves
    // it unassigned; a missing default here would infer a latch.
    state_next   = state;
    pending_next = pending;
    count_next   = count;
    hit_next     = hit;
    case (state)
      IDLE: begin
        if (start) begin
          pending_next = match_vec;
          count_next   = '0;
          hit_next     = 1'b0;
          state_next   = (match_vec != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (handshake) begin
          pending_next = pending_low_cleared;
          count_next   = count + (ADDR_WIDTH+1)'(1);
          if (m_last) state_next = DONE;
        end
      end
      DONE: begin
        hit_next   = (count != '0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: pending is a plain flop vector, not a RAM, so it is reset along with the
  // FSM; an aborted scan must never leak stale bits into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
      hit     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of
      // statement order.
      state   <= state_next;
      pending <= pending_next;
      count   <= count_next;
      hit     <= hit_next;
    end
  end

endmodule

// File: tb/tb_cam_match_scan.sv
// Self-checking bench for cam_match_scan: directed table, hand-written reset
// sequences and randomized scans against a queue-based reference model.
module tb_cam_match_scan;

  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  match_vec;
  logic          busy;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic          m_last;
  logic          done;
  logic          hit;
  logic [AW:0]   hit_count;

  int checks = 0;
  int errors = 0;

  cam_match_scan #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .match_vec (match_vec),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_last    (m_last),
    .done      (done),
    .hit       (hit),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"},      32'(busy),      0);
    check({name, " m_valid"},   32'(m_valid),   0);
    check({name, " m_addr"},    32'(m_addr),    0);
    check({name, " m_last"},    32'(m_last),    0);
    check({name, " done"},      32'(done),      0);
    check({name, " hit"},       32'(hit),       0);
    check({name, " hit_count"}, 32'(hit_count), 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 3 scan cycles, then high.
  // exp_first/exp_count < 0 means "no hand-computed expectation, model only".
  task automatic run_scan(input string name, input logic [N-1:0] vec, input int mode,
                          input bit inject, input int exp_first, input int exp_count);
    int exp_q[$];
    int emitted;
    int c;
    int k;
    bit rdy;
    for (int i = 0; i < N; i++) if (vec[i]) exp_q.push_back(i);
    k = exp_q.size();

    @(negedge clk);
    start     = 1'b1;
    match_vec = vec;
    m_ready   = (mode == 0);
    @(negedge clk);
    start     = 1'b0;
    match_vec = N'($urandom);
    check({name, " busy after start"}, 32'(busy), 1);
    check({name, " hit cleared"},      32'(hit),  0);

    c = 1;
    emitted = 0;
    while (exp_q.size() != 0) begin
      if (c > 200) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: got no completion required %0d indices", name, k);
        break;
      end
      check({name, " m_valid"},   32'(m_valid),   1);
      check({name, " m_addr"},    32'(m_addr),    32'(exp_q[0]));
      check({name, " m_last"},    32'(m_last),    32'(exp_q.size() == 1));
      check({name, " hit_count"}, 32'(hit_count), 32'(emitted));
      check({name, " done early"}, 32'(done),     0);
      check({name, " busy"},      32'(busy),      1);
      if (c == 1 && exp_first >= 0) check({name, " first addr"}, 32'(m_addr), 32'(exp_first));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (c > 3);
      endcase
      m_ready = rdy;
      if (inject && c == 2) begin
        start     = 1'b1;
        match_vec = 16'h0001;
      end
      @(negedge clk);
      start = 1'b0;
      if (rdy) begin
        void'(exp_q.pop_front());
        emitted++;
      end
      c++;
    end

    m_ready = 1'($urandom_range(0, 1));
    check({name, " done pulse"},     32'(done),      1);
    check({name, " busy in done"},   32'(busy),      1);
    check({name, " valid in done"},  32'(m_valid),   0);
    check({name, " addr in done"},   32'(m_addr),    0);
    check({name, " last in done"},   32'(m_last),    0);
    check({name, " count in done"},  32'(hit_count), 32'(k));
    check({name, " hit pre-update"}, 32'(hit),       0);
    if (mode == 0) check({name, " done latency"}, 32'(c), 32'(k + 1));
    @(negedge clk);
    check({name, " done one cycle"}, 32'(done),      0);
    check({name, " busy fell"},      32'(busy),      0);
    check({name, " hit"},            32'(hit),       32'(k != 0));
    check({name, " count held"},     32'(hit_count), 32'(k));
    if (exp_count >= 0) check({name, " hit_count table"}, 32'(hit_count), 32'(exp_count));
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] vec;
    int           mode;
    bit           inject;
    int           exp_first;
    int           exp_count;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [N-1:0] rv;

    tbl[0] = '{"single",    16'h0020, 0, 1'b0,  5,  1};
    tbl[1] = '{"multi",     16'h8103, 0, 1'b0,  0,  4};
    tbl[2] = '{"backpress", 16'h0012, 2, 1'b0,  1,  2};
    tbl[3] = '{"empty",     16'h0000, 0, 1'b0, -1,  0};
    tbl[4] = '{"full_ign",  16'hFFFF, 0, 1'b1,  0, 16};
    tbl[5] = '{"top_rand",  16'h8000, 1, 1'b0, 15,  1};

    rst       = 1'b0;
    start     = 1'b0;
    match_vec = '0;
    m_ready   = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post reset");

    foreach (tbl[i]) begin
      run_scan(tbl[i].name, tbl[i].vec, tbl[i].mode, tbl[i].inject,
               tbl[i].exp_first, tbl[i].exp_count);
    end

    // Reset mid-scan after two of four handshakes.
    @(negedge clk);
    start     = 1'b1;
    match_vec = 16'h8103;
    m_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort first addr", 32'(m_addr), 0);
    @(negedge clk);
    check("abort second addr", 32'(m_addr), 1);
    @(negedge clk);
    check("abort third addr", 32'(m_addr), 8);
    check("abort count", 32'(hit_count), 2);
    m_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("abort async");
    @(negedge clk);
    check("abort no done in reset", 32'(done), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no done", 32'(done), 0);
      check("abort idle", 32'(busy), 0);
      check("abort no valid", 32'(m_valid), 0);
    end
    run_scan("after_abort", 16'h0020, 0, 1'b0, 5, 1);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = '0;
        1:       rv = N'($urandom) & N'($urandom) & N'($urandom);
        default: rv = N'($urandom);
      endcase
      run_scan("random", rv, (i % 4 == 0) ? 0 : 1, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
